// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a prescaler strobes a step tick that advances
// one of four patterns (binary count, bouncing scan, PWM breathe, solid) on NUM_LEDS outputs.
module led_pattern_gen #(
  parameter int NUM_LEDS = 5,
  parameter int TICK_DIV = 1200000,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic                tick,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]       PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);
  localparam logic [SW-1:0]       POS_LAST   = SW'(NUM_LEDS - 1);
  localparam logic [SW-1:0]       POS_ZERO   = SW'(0);
  localparam logic [SW-1:0]       POS_ONE    = SW'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
  localparam logic [NUM_LEDS-1:0] LEDS_OFF   = {NUM_LEDS{1'b0}};
  localparam logic [NUM_LEDS-1:0] LEDS_ON    = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] LED_ONE    = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'b00,
    MODE_SCAN    = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_SOLID   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PW-1:0]       presc_r,       presc_s;
  mode_e               active_mode_r, active_mode_s;
  logic [NUM_LEDS-1:0] bin_cnt_r,     bin_cnt_s;
  logic [SW-1:0]       scan_pos_r,    scan_pos_s;
  dir_e                scan_dir_r,    scan_dir_s;
  logic [PWM_BITS-1:0] duty_r,        duty_s;
  dir_e                duty_dir_r,    duty_dir_s;
  logic [PWM_BITS-1:0] pwm_cnt_r,     pwm_cnt_s;
  logic [NUM_LEDS-1:0] leds_r,        leds_s;
  logic                tick_s;
  logic                pwm_on_s;

  assign tick_s   = enable && (presc_r == PRESC_LAST);
  assign pwm_on_s = (pwm_cnt_r < duty_r);
  assign tick     = tick_s;
  assign leds     = leds_r;

  // Next-state logic: prescaler, PWM counter, mode load and one pattern step per tick.
  always_comb begin
    presc_s       = presc_r;
    pwm_cnt_s     = pwm_cnt_r;
    active_mode_s = active_mode_r;
    bin_cnt_s     = bin_cnt_r;
    scan_pos_s    = scan_pos_r;
    scan_dir_s    = scan_dir_r;
    duty_s        = duty_r;
    duty_dir_s    = duty_dir_r;
    if (enable) begin
      pwm_cnt_s = pwm_cnt_r + PWM_ONE;
      if (presc_r == PRESC_LAST) begin
        presc_s = PRESC_ZERO;
      end else begin
        presc_s = presc_r + PRESC_ONE;
      end
      if (tick_s) begin
        // A new mode restarts its pattern from scratch; the loading tick does not advance it.
        if (mode_e'(mode) != active_mode_r) begin
          active_mode_s = mode_e'(mode);
          bin_cnt_s     = LEDS_OFF;
          scan_pos_s    = POS_ZERO;
          scan_dir_s    = DIR_UP;
          duty_s        = DUTY_ZERO;
          duty_dir_s    = DIR_UP;
        end else begin
          case (active_mode_r)
            MODE_BINARY: bin_cnt_s = bin_cnt_r + LED_ONE;
            MODE_SCAN: begin
              if (scan_dir_r == DIR_UP) begin
                if (scan_pos_r < POS_LAST) begin
                  scan_pos_s = scan_pos_r + POS_ONE;
                  scan_dir_s = (scan_pos_s == POS_LAST) ? DIR_DOWN : DIR_UP;
                end else begin
                  scan_pos_s = scan_pos_r;
                end
              end else begin
                if (scan_pos_r > POS_ZERO) begin
                  scan_pos_s = scan_pos_r - POS_ONE;
                  scan_dir_s = (scan_pos_s == POS_ZERO) ? DIR_UP : DIR_DOWN;
                end else begin
                  scan_pos_s = scan_pos_r;
                end
              end
            end
            MODE_BREATHE: begin
              if (duty_dir_r == DIR_UP) begin
                if (duty_r < DUTY_MAX) begin
                  duty_s     = duty_r + PWM_ONE;
                  duty_dir_s = (duty_s == DUTY_MAX) ? DIR_DOWN : DIR_UP;
                end else begin
                  duty_s = duty_r;
                end
              end else begin
                if (duty_r > DUTY_ZERO) begin
                  duty_s     = duty_r - PWM_ONE;
                  duty_dir_s = (duty_s == DUTY_ZERO) ? DIR_UP : DIR_DOWN;
                end else begin
                  duty_s = duty_r;
                end
              end
            end
            MODE_SOLID: bin_cnt_s = bin_cnt_r;
            default:    bin_cnt_s = bin_cnt_r;
          endcase
        end
      end else begin
        active_mode_s = active_mode_r;
      end
    end else begin
      presc_s = presc_r;
    end
  end

  // LED image of the current pattern state, registered on the next enabled edge.
  always_comb begin
    leds_s = LEDS_OFF;
    case (active_mode_r)
      MODE_BINARY:  leds_s = bin_cnt_r;
      MODE_SCAN:    leds_s = LED_ONE << scan_pos_r;
      MODE_BREATHE: leds_s = {NUM_LEDS{pwm_on_s}};
      MODE_SOLID:   leds_s = LEDS_ON;
      default:      leds_s = LEDS_OFF;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r       <= PRESC_ZERO;
      active_mode_r <= MODE_BINARY;
      bin_cnt_r     <= LEDS_OFF;
      scan_pos_r    <= POS_ZERO;
      scan_dir_r    <= DIR_UP;
      duty_r        <= DUTY_ZERO;
      duty_dir_r    <= DIR_UP;
      pwm_cnt_r     <= DUTY_ZERO;
      leds_r        <= LEDS_OFF;
    end else begin
      presc_r       <= presc_s;
      active_mode_r <= active_mode_s;
      bin_cnt_r     <= bin_cnt_s;
      scan_pos_r    <= scan_pos_s;
      scan_dir_r    <= scan_dir_s;
      duty_r        <= duty_s;
      duty_dir_r    <= duty_dir_s;
      pwm_cnt_r     <= pwm_cnt_s;
      if (enable) begin
        leds_r <= leds_s;
      end else begin
        leds_r <= leds_r;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: three instances (4 LEDs / 1 LED / slow tick) checked
// every cycle against a step-count model, plus hand-computed literal expectations.
module tb_led_pattern_gen;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic       tick0, tick1, tick2;
  logic [3:0] leds0;
  logic [0:0] leds1;
  logic [3:0] leds2;

  int td [NI] = '{4, 4, 16};
  int nl [NI] = '{4, 1, 4};

  int         m_ecnt [NI] = '{0, 0, 0};
  int         m_mode [NI] = '{0, 0, 0};
  int         m_k    [NI] = '{0, 0, 0};
  logic [3:0] m_leds [NI] = '{4'h0, 4'h0, 4'h0};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LEDS(4), .TICK_DIV(4), .PWM_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .tick(tick0), .leds(leds0));
  led_pattern_gen #(.NUM_LEDS(1), .TICK_DIV(4), .PWM_BITS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .tick(tick1), .leds(leds1));
  led_pattern_gen #(.NUM_LEDS(4), .TICK_DIV(16), .PWM_BITS(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .tick(tick2), .leds(leds2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Triangle wave 0,1,..,max,max-1,..,1,0,1,.. without repeated end points.
  function automatic int tri_wave(input int k, input int max);
    int r;
    if (max == 0) return 0;
    r = k % (2 * max);
    return (r <= max) ? r : (2 * max - r);
  endfunction

  // Expected LED image for a pattern that has taken k steps since it was loaded.
  function automatic logic [3:0] pat(input int n, input int md, input int k, input int pwm);
    logic [3:0] all_on;
    all_on = (n == 4) ? 4'hF : 4'h1;
    case (md)
      0:       pat = 4'(k % (1 << n));
      1:       pat = 4'(1 << tri_wave(k, n - 1));
      2:       pat = (pwm < tri_wave(k, 7)) ? all_on : 4'h0;
      default: pat = all_on;
    endcase
  endfunction

  function automatic logic [31:0] exp_tick(input int i);
    return 32'(enable && (m_ecnt[i] % td[i] == td[i] - 1));
  endfunction

  // Model: counts enabled cycles and steps since the last mode load.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_ecnt[i] <= 0;
        m_mode[i] <= 0;
        m_k[i]    <= 0;
        m_leds[i] <= 4'h0;
      end
    end else if (enable) begin
      for (int i = 0; i < NI; i++) begin
        m_leds[i] <= pat(nl[i], m_mode[i], m_k[i], m_ecnt[i] % 8);
        if (m_ecnt[i] % td[i] == td[i] - 1) begin
          if (int'(mode) != m_mode[i]) begin
            m_mode[i] <= int'(mode);
            m_k[i]    <= 0;
          end else begin
            m_k[i] <= m_k[i] + 1;
          end
        end
        m_ecnt[i] <= m_ecnt[i] + 1;
      end
    end
  end

  // Per-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      chk("model_tick0", 32'(tick0), exp_tick(0));
      chk("model_tick1", 32'(tick1), exp_tick(1));
      chk("model_tick2", 32'(tick2), exp_tick(2));
      chk("model_leds0", 32'(leds0), 32'(m_leds[0]));
      chk("model_leds1", 32'(leds1), 32'(m_leds[1]));
      chk("model_leds2", 32'(leds2), 32'(m_leds[2]));
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic startup_checks();
    goto(1); chk("first_tick_e1", 32'(tick0), 32'h0);
    goto(2); chk("first_tick_e2", 32'(tick0), 32'h0);
    goto(3); chk("first_tick_e3", 32'(tick0), 32'h1);
    goto(4); chk("first_leds_e4", 32'(leds0), 32'h0);
    goto(5); chk("first_leds_e5", 32'(leds0), 32'h1);
  endtask

  logic [3:0] scan_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0100, 4'b0010, 4'b0001, 4'b0010};
  int duty_exp [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    int guard;
    int hi;
    rst_n  = 1'b0;
    enable = 1'b1;
    mode   = 2'b00;
    #3;
    chk("reset_leds", 32'(leds0), 32'h0);
    chk("reset_tick", 32'(tick0), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    startup_checks();

    goto(21);
    chk("binary_0101", 32'(leds0), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(leds0), 32'h0);
    chk("async_rst_tick", 32'(tick0), 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    startup_checks();

    goto(61); chk("binary_1111", 32'(leds0), 32'hF);
    goto(65); chk("binary_wrap", 32'(leds0), 32'h0);

    goto(68); mode = 2'b11;
    goto(72); chk("solid_wait", 32'(leds0), 32'h1);
    goto(73); chk("solid_on", 32'(leds0), 32'hF);
    mode = 2'b00;
    goto(77); chk("binary_restart0", 32'(leds0), 32'h0);
    goto(81); chk("binary_restart1", 32'(leds0), 32'h1);

    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      goto(85 + 4 * i);
      chk("scan_seq", 32'(leds0), 32'(scan_exp[i]));
      chk("scan_one_led", 32'(leds1), 32'h1);
    end

    goto(117);
    chk("freeze_start", 32'(leds0), 32'h4);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      goto(118 + i);
      chk("freeze_tick", 32'(tick0), 32'h0);
      chk("freeze_leds", 32'(leds0), 32'h4);
    end
    enable = 1'b1;
    goto(138); chk("resume_no_tick", 32'(tick0), 32'h0);
    goto(139); chk("resume_tick", 32'(tick0), 32'h1);
    goto(141); chk("resume_step", 32'(leds0), 32'h8);

    mode = 2'b10;
    for (int i = 0; i < 16; i++) begin
      chk("duty_model", 32'(tri_wave(i, 7)), 32'(duty_exp[i]));
    end
    for (int i = 145; i <= 148; i++) begin
      goto(i);
      chk("duty0_off", 32'(leds0), 32'h0);
    end

    guard = 0;
    while (!(m_mode[2] == 2 && m_k[2] == 3) && guard < 300) begin
      goto(cyc + 1);
      guard++;
    end
    chk("duty3_reached", 32'(guard < 300), 32'h1);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      goto(cyc + 1);
      if (leds2 == 4'hF) hi++;
    end
    chk("duty3_ontime", 32'(hi), 32'h6);

    goto(cyc + 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED driver; successor to the free-running counter blinker.
- A programmable prescaler produces a slow step tick.
- The tick advances one of four selectable patterns across NUM_LEDS outputs: binary count, bouncing scan, PWM breathe, solid on.
- Sits between the board clock and the LED pins. Mode is driven by switches or a control register.

Parameters:
- NUM_LEDS, 5: number of LED outputs; must be >= 1.
- TICK_DIV, 1200000: clk cycles per step tick; must be >= 2 (1200000 gives 10 Hz at 12 MHz).
- PWM_BITS, 8: width of the PWM counter and duty register for BREATHE mode; must be >= 1.

Ports:
- clk, input, 1: system clock (12 MHz on board).
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: high = run; low = freeze all counters and outputs.
- mode, input, 2: requested pattern. 00 BINARY, 01 SCAN, 10 BREATHE, 11 SOLID.
- tick, output, 1: step strobe, high for one cycle per step.
- leds, output, NUM_LEDS: LED drive, active high, registered.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-pattern) forces:
  - presc=0, active_mode=BINARY, bin_cnt=0, scan_pos=0, scan_dir=UP, duty=0, duty_dir=UP, pwm_cnt=0.
  - leds=0, tick=0 immediately, without waiting for a clock edge.
- Prescaler:
  - presc counts 0..TICK_DIV-1 on each clk edge while enable=1, then wraps to 0.
  - tick = enable && (presc==TICK_DIV-1). It is a decode of the register, so exactly one cycle high per TICK_DIV enabled cycles.
  - First tick comes TICK_DIV-1 enabled edges after reset release.
- Step state updates only on an edge where tick=1.
- Mode change:
  - mode is sampled only on tick edges.
  - If mode != active_mode: load active_mode=mode and reset all pattern state to its reset values. No advance on that tick.
  - Otherwise the active pattern advances one step.
  - Mode changes between ticks have no effect until the next tick.
- BINARY: bin_cnt (NUM_LEDS bits) += 1 per tick and wraps from all-ones to 0. leds = bin_cnt.
- SCAN, a two-state FSM (UP/DOWN) on scan_pos in 0..NUM_LEDS-1:
  - UP: pos+1. When pos reaches NUM_LEDS-1, switch to DOWN.
  - DOWN: pos-1. When pos reaches 0, switch to UP.
  - End LEDs are not repeated. With NUM_LEDS=1, pos stays 0.
  - leds = one-hot(scan_pos).
- BREATHE:
  - pwm_cnt (PWM_BITS) increments every enabled cycle and wraps.
  - duty FSM (UP/DOWN): +1 per tick until 2^PWM_BITS-1, then DOWN; -1 per tick until 0, then UP. The end values are not repeated.
  - All leds = (pwm_cnt < duty). duty=0 is fully off; max duty gives on-time (2^PWM_BITS-1)/2^PWM_BITS.
- SOLID: leds = all ones.
- leds is a registered output: it reflects the pattern state one clk edge after that state changes.
- enable=0:
  - presc, pwm_cnt and all pattern state hold; leds holds its last value; tick=0.
  - Resuming continues from the held values.
- No arithmetic overflow is permitted except the documented wraps of presc, bin_cnt and pwm_cnt.

Test Plan (NUM_LEDS=4, TICK_DIV=4, PWM_BITS=3 unless stated):
- Reset: run BINARY to leds=0101, then pulse rst_n low between clock edges -> leds=0 and tick=0 at once; after release, first tick after 3 edges; leds=0001 one edge later.
- BINARY wrap: mode=00 for 16 ticks -> leds steps 0001..1111, then 0000; tick period exactly 4 cycles.
- SCAN bounce: mode=01 -> after the mode-load tick leds=0001, then per tick 0010, 0100, 1000, 0100, 0010, 0001, 0010; repeat with NUM_LEDS=1 -> leds stays 1.
- BREATHE: mode=10 -> duty sequence 0,1,...,7,6,...,0,1 per tick; while duty=3, leds=1111 for exactly 3 of every 8 cycles; while duty=0, leds never high.
- Mode switch timing: change mode 00->11 one cycle after a tick -> leds unchanged until the next tick, then 1111; switch back to 00 -> bin_cnt restarts at 0.
- Enable freeze: drop enable for 20 cycles in SCAN at leds=0100 -> tick stays 0 and leds holds 0100; after re-enable, next tick arrives after the remaining prescaler count with no skipped step.
